// File: rtl/alu_issue_stage_if.sv
// Bundle of every signal between the ALU issue stage and its neighbours:
// the fetch-side handshake, the register-file read ports and the ALU-side
// handshake. The stage itself uses the slave view; fetch, regfile and ALU
// together form the master view.
interface alu_issue_stage_if #(
    parameter int DATA_W = 32,
    parameter int OPC_W  = 4,
    parameter int REG_AW = 5
);
    // Fetch side
    logic              in_valid;
    logic              in_ready;
    logic [31:0]       in_instr;

    // Register-file read ports (asynchronous read)
    logic [REG_AW-1:0] rs1_addr;
    logic [REG_AW-1:0] rs2_addr;
    logic [DATA_W-1:0] rs1_data;
    logic [DATA_W-1:0] rs2_data;

    // ALU side
    logic              out_valid;
    logic              out_ready;
    logic [OPC_W-1:0]  out_opcode;
    logic [DATA_W-1:0] out_num1;
    logic [DATA_W-1:0] out_num2;
    logic [REG_AW-1:0] out_rd;
    logic              out_illegal;

    modport slave (
        input  in_valid, in_instr, rs1_data, rs2_data, out_ready,
        output in_ready, rs1_addr, rs2_addr,
               out_valid, out_opcode, out_num1, out_num2, out_rd, out_illegal
    );

    modport master (
        output in_valid, in_instr, rs1_data, rs2_data, out_ready,
        input  in_ready, rs1_addr, rs2_addr,
               out_valid, out_opcode, out_num1, out_num2, out_rd, out_illegal
    );
endinterface

// File: rtl/alu_issue_stage.sv
// ALU issue stage: decodes RV32I register/immediate ALU instructions, reads
// the operands from the register file in the accept cycle and issues
// opcode/operands/rd/illegal through a two-entry skid buffer. in_ready is a
// flop, so there is no combinational path from out_ready back to fetch.
module alu_issue_stage #(
    parameter int DATA_W = 32,
    parameter int OPC_W  = 4,
    parameter int REG_AW = 5
) (
    input  logic clk,
    input  logic rst_n,
    alu_issue_stage_if.slave bus
);

    localparam logic [6:0] MAJ_OP     = 7'b0110011;
    localparam logic [6:0] MAJ_OP_IMM = 7'b0010011;
    localparam logic [6:0] F7_BASE    = 7'b0000000;
    localparam logic [6:0] F7_ALT     = 7'b0100000;

    localparam logic [OPC_W-1:0] ALU_ADD  = OPC_W'(0);
    localparam logic [OPC_W-1:0] ALU_SUB  = OPC_W'(1);
    localparam logic [OPC_W-1:0] ALU_AND  = OPC_W'(2);
    localparam logic [OPC_W-1:0] ALU_OR   = OPC_W'(3);
    localparam logic [OPC_W-1:0] ALU_XOR  = OPC_W'(4);
    localparam logic [OPC_W-1:0] ALU_SLTU = OPC_W'(5);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FULL  = 2'd1,
        SKID  = 2'd2
    } state_t;

    typedef struct packed {
        logic [OPC_W-1:0]  opcode;
        logic [DATA_W-1:0] num1;
        logic [DATA_W-1:0] num2;
        logic [REG_AW-1:0] rd;
        logic              illegal;
    } entry_t;

    state_t      state;
    entry_t      m;            // output register, drives out_*
    entry_t      s;            // skid register, second entry
    entry_t      dec;
    logic        out_valid_q;
    logic        in_ready_q;
    logic        accept;
    logic        legal;
    logic        f3_ok;
    logic [OPC_W-1:0] f3_op;

    logic [6:0]  major;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [DATA_W-1:0] imm;

    assign major  = bus.in_instr[6:0];
    assign f3     = bus.in_instr[14:12];
    assign f7     = bus.in_instr[31:25];
    assign imm    = {{(DATA_W-12){bus.in_instr[31]}}, bus.in_instr[31:20]};
    assign accept = bus.in_valid && in_ready_q;

    assign bus.rs1_addr = bus.in_instr[19:15];
    assign bus.rs2_addr = bus.in_instr[24:20];

    // Decode the incoming word into an ALU entry; anything unsupported becomes an all-zero entry flagged illegal.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned, which would infer a latch.
        dec   = '0;
        legal = 1'b0;
        f3_ok = 1'b1;
        f3_op = ALU_ADD;
        case (f3)
            3'b000:  f3_op = ALU_ADD;
            3'b100:  f3_op = ALU_XOR;
            3'b110:  f3_op = ALU_OR;
            3'b111:  f3_op = ALU_AND;
            3'b011:  f3_op = ALU_SLTU;
            default: f3_ok = 1'b0;   // shifts, SLT/SLTI
        endcase

        case (major)
            MAJ_OP: begin
                dec.num2 = bus.rs2_data;
                if (f7 == F7_BASE && f3_ok) begin
                    legal      = 1'b1;
                    dec.opcode = f3_op;
                end else if (f7 == F7_ALT && f3 == 3'b000) begin
                    legal      = 1'b1;
                    dec.opcode = ALU_SUB;
                end
            end
            MAJ_OP_IMM: begin
                dec.num2 = imm;
                if (f3_ok) begin
                    legal      = 1'b1;
                    dec.opcode = f3_op;
                end
            end
            default: legal = 1'b0;
        endcase

        if (legal) begin
            dec.num1 = bus.rs1_data;
            dec.rd   = bus.in_instr[11:7];
        end else begin
            dec         = '0;
            dec.illegal = 1'b1;
        end
    end

    // Skid-buffer FSM: owns state, both entry registers and the registered handshake outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: data registers are reset too, so out_* read as zero after reset rather than stale values.
        if (!rst_n) begin
            state       <= EMPTY;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            m           <= '0;
            s           <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            case (state)
                EMPTY: begin
                    if (accept) begin
                        m           <= dec;
                        state       <= FULL;
                        out_valid_q <= 1'b1;
                    end
                end
                FULL: begin
                    if (accept && bus.out_ready) begin
                        m <= dec;
                    end else if (accept) begin
                        s          <= dec;
                        state      <= SKID;
                        in_ready_q <= 1'b0;
                    end else if (bus.out_ready) begin
                        state       <= EMPTY;
                        out_valid_q <= 1'b0;
                    end
                end
                SKID: begin
                    if (bus.out_ready) begin
                        m          <= s;
                        state      <= FULL;
                        in_ready_q <= 1'b1;
                    end
                end
                default: begin
                    state       <= EMPTY;
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                end
            endcase
        end
    end

    assign bus.in_ready    = in_ready_q;
    assign bus.out_valid   = out_valid_q;
    assign bus.out_opcode  = m.opcode;
    assign bus.out_num1    = m.num1;
    assign bus.out_num2    = m.num2;
    assign bus.out_rd      = m.rd;
    assign bus.out_illegal = m.illegal;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage. Expected entries are written out by
// hand per instruction, queued when the stage accepts the instruction and
// compared against out_* whenever out_valid is high (the head must be
// presented and held until out_ready consumes it).
module tb_alu_issue_stage;

    typedef struct packed {
        logic [3:0]  op;
        logic [31:0] n1;
        logic [31:0] n2;
        logic [4:0]  rd;
        logic        ill;
    } exp_t;

    logic clk;
    logic rst_n;
    logic [31:0] regs [32];

    exp_t q [$];
    int   checks;
    int   errors;
    int   pop_count;

    alu_issue_stage_if bus ();

    alu_issue_stage dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Register-file model: asynchronous read
    assign bus.rs1_data = regs[bus.rs1_addr];
    assign bus.rs2_data = regs[bus.rs2_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Output monitor: sampled on the falling edge, between the drive points
    always @(negedge clk) begin
        if (rst_n && bus.out_valid) begin
            if (q.size() == 0) begin
                check("unexpected_issue", 80'(bus.out_valid), 80'(1'b0));
            end else begin
                check("issue",
                      80'({bus.out_opcode, bus.out_num1, bus.out_num2, bus.out_rd, bus.out_illegal}),
                      80'(q[0]));
                if (bus.out_ready) begin
                    void'(q.pop_front());
                    pop_count++;
                end
            end
        end
    end

    // Present one instruction until accepted; queue its expected entry on acceptance
    task automatic send(input logic [31:0] instr, input logic [3:0] op, input logic [31:0] n1,
                        input logic [31:0] n2, input logic [4:0] rd, input logic ill);
        logic done;
        done = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_instr = instr;
        #1;
        check("rs_addr", 80'({bus.rs1_addr, bus.rs2_addr}), 80'({instr[19:15], instr[24:20]}));
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                q.push_back({op, n1, n2, rd, ill});
                done = 1'b1;
            end
            @(posedge clk);
            #1;
            if (done) break;
        end
        bus.in_valid = 1'b0;
        check("accept_timeout", 80'(done), 80'(1'b1));
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 50; i++) begin
            if (q.size() == 0) break;
            @(posedge clk);
            #1;
        end
        check("drain", 80'(q.size()), 80'(0));
    endtask

    task automatic check_idle_outputs(input string tag);
        check(tag, 80'({bus.out_valid, bus.in_ready, bus.out_opcode, bus.out_num1,
                        bus.out_num2, bus.out_rd, bus.out_illegal}),
              80'({1'b0, 1'b1, 4'd0, 32'd0, 32'd0, 5'd0, 1'b0}));
    endtask

    initial begin
        int pops_before;
        checks    = 0;
        errors    = 0;
        pop_count = 0;
        for (int i = 0; i < 32; i++) regs[i] = '0;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_instr  = '0;
        bus.out_ready = 1'b1;

        // Reset state
        #12;
        check_idle_outputs("reset_values");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // ADD x3,x1,x2 with one-cycle latency
        regs[1] = 32'd5;
        regs[2] = 32'd7;
        send(32'h002081B3, 4'd0, 32'd5, 32'd7, 5'd3, 1'b0);
        check("latency_out_valid", 80'(bus.out_valid), 80'(1'b1));
        wait_drain();

        // Immediate forms and the remaining R-type ops, streamed back to back
        regs[1] = 32'd10;
        send(32'hFFF08213, 4'd0, 32'd10, 32'hFFFFFFFF, 5'd4, 1'b0);  // ADDI x4,x1,-1
        send(32'h402081B3, 4'd1, 32'd10, 32'd7,        5'd3, 1'b0);  // SUB
        send(32'hFFF0B193, 4'd5, 32'd10, 32'hFFFFFFFF, 5'd3, 1'b0);  // SLTIU -1
        send(32'h0020C2B3, 4'd4, 32'd10, 32'd7,        5'd5, 1'b0);  // XOR
        send(32'h0020F3B3, 4'd2, 32'd10, 32'd7,        5'd7, 1'b0);  // AND
        send(32'h0020E433, 4'd3, 32'd10, 32'd7,        5'd8, 1'b0);  // OR
        send(32'h0020B4B3, 4'd5, 32'd10, 32'd7,        5'd9, 1'b0);  // SLTU
        send(32'h7FF0E313, 4'd3, 32'd10, 32'h000007FF, 5'd6, 1'b0);  // ORI +2047
        send(32'h8000F013, 4'd2, 32'd10, 32'hFFFFF800, 5'd0, 1'b0);  // ANDI x0,-2048
        wait_drain();

        // Illegal encodings
        send(32'h002091B3, 4'd0, 32'd0, 32'd0, 5'd0, 1'b1);  // SLL
        send(32'h0020A1B3, 4'd0, 32'd0, 32'd0, 5'd0, 1'b1);  // SLT
        send(32'h4020C1B3, 4'd0, 32'd0, 32'd0, 5'd0, 1'b1);  // XOR with bad f7
        send(32'h022081B3, 4'd0, 32'd0, 32'd0, 5'd0, 1'b1);  // MUL
        send(32'hFFF0A193, 4'd0, 32'd0, 32'd0, 5'd0, 1'b1);  // SLTI
        send(32'h4010D193, 4'd0, 32'd0, 32'd0, 5'd0, 1'b1);  // SRAI
        send(32'h00002083, 4'd0, 32'd0, 32'd0, 5'd0, 1'b1);  // LW
        wait_drain();

        // Back-pressure: fill to the skid entry, hold, then release
        regs[1] = 32'd1;
        regs[2] = 32'd2;
        bus.out_ready = 1'b0;
        pops_before = pop_count;
        send(32'h002081B3, 4'd0, 32'd1, 32'd2,        5'd3, 1'b0);  // A
        send(32'hFFF08213, 4'd0, 32'd1, 32'hFFFFFFFF, 5'd4, 1'b0);  // B
        check("skid_in_ready_low", 80'(bus.in_ready), 80'(1'b0));
        check("skid_holds_a_rd", 80'(bus.out_rd), 80'(5'd3));
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check("skid_hold_in_ready", 80'({bus.out_valid, bus.in_ready}), 80'(2'b10));
        end
        bus.out_ready = 1'b1;
        wait_drain();
        check("skid_pop_count", 80'(pop_count - pops_before), 80'(2));
        check("skid_in_ready_back", 80'(bus.in_ready), 80'(1'b1));

        // Asynchronous reset while in the skid state
        bus.out_ready = 1'b0;
        send(32'h0020C2B3, 4'd4, 32'd1, 32'd2, 5'd5, 1'b0);
        send(32'h0020E433, 4'd3, 32'd1, 32'd2, 5'd8, 1'b0);
        check("pre_reset_in_ready", 80'(bus.in_ready), 80'(1'b0));
        #3;
        rst_n = 1'b0;
        q.delete();
        #1;
        check_idle_outputs("async_reset_values");
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            check("post_reset_quiet", 80'(bus.out_valid), 80'(1'b0));
        end

        // Recovery after reset
        regs[1] = 32'h80000000;
        regs[2] = 32'h00000001;
        send(32'h402081B3, 4'd1, 32'h80000000, 32'h00000001, 5'd3, 1'b0);
        wait_drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
